// File: rtl/scan_index_seq.sv
// Index sequencer for the 3-to-8 decoder: walks the enabled channels of a
// latched 8-bit mask in ascending order, holding each index for dwell+1 cycles.
module scan_index_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         idx,
  output logic               idx_valid,
  output logic               step,
  output logic               sweep_done,
  output logic               busy,
  output logic               dbg_state
);

  // Handshake: start is a level sampled only in IDLE on a rising edge; stop is
  // honoured in any state and beats both start and an advance in the same cycle.

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

  state_t             state_q;
  logic [2:0]         idx_q;
  logic               valid_q;
  logic               step_q;
  logic               done_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [3:0] lowest_set(input logic [7:0] m);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [3:0] first_d;
  logic [3:0] next_d;
  logic [3:0] wrap_d;

  always_comb begin
    first_d = lowest_set(ch_mask);
    // 8'hFE << idx keeps only bit positions strictly above the current index.
    next_d  = lowest_set(mask_q & (8'hFE << idx_q));
    wrap_d  = lowest_set(mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= 8'h00;
      dwell_q <= '0;
      cont_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop && (ch_mask != 8'h00)) begin
            mask_q  <= ch_mask;
            dwell_q <= dwell;
            cont_q  <= continuous;
            idx_q   <= first_d[2:0];
            valid_q <= 1'b1;
            step_q  <= 1'b1;
            cnt_q   <= dwell;
            state_q <= DWELL;
          end
        end
        DWELL: begin
          if (stop) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (next_d[3]) begin
            idx_q  <= next_d[2:0];
            step_q <= 1'b1;
            cnt_q  <= dwell_q;
          end else begin
            done_q <= 1'b1;
            if (cont_q) begin
              idx_q  <= wrap_d[2:0];
              step_q <= 1'b1;
              cnt_q  <= dwell_q;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = valid_q;
  assign step       = step_q;
  assign sweep_done = done_q;
  assign busy       = (state_q == DWELL);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_scan_index_seq.sv
// Directed bench for scan_index_seq: a per-cycle vector table for the basic
// sweeps, plus hand-written continuous-mode and stop sequences.
module tb_scan_index_seq;

  logic       clk = 1'b0;
  logic       rst, start, stop, continuous;
  logic [7:0] ch_mask, dwell;
  logic [2:0] idx;
  logic       idx_valid, step, sweep_done, busy, dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  scan_index_seq #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .ch_mask(ch_mask), .dwell(dwell), .idx(idx), .idx_valid(idx_valid),
    .step(step), .sweep_done(sweep_done), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       r, st, sp, c;
    logic [7:0] m, d;
    logic [2:0] e_idx;
    logic       e_v, e_s, e_d, e_b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic r, logic st, logic sp, logic c,
                              logic [7:0] m, logic [7:0] d, logic [2:0] ei,
                              logic ev, logic es, logic ed, logic eb);
    vec_t v;
    v.name = nm; v.r = r; v.st = st; v.sp = sp; v.c = c; v.m = m; v.d = d;
    v.e_idx = ei; v.e_v = ev; v.e_s = es; v.e_d = ed; v.e_b = eb;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic st, input logic sp, input logic c,
                       input logic [7:0] m, input logic [7:0] d);
    @(negedge clk);
    rst = r; start = st; stop = sp; continuous = c; ch_mask = m; dwell = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string nm, input logic [2:0] ei, input logic ev,
                            input logic es, input logic ed, input logic eb);
    check({nm, ".idx"},   {5'd0, idx}, {5'd0, ei});
    check({nm, ".valid"}, {7'd0, idx_valid}, {7'd0, ev});
    check({nm, ".step"},  {7'd0, step}, {7'd0, es});
    check({nm, ".done"},  {7'd0, sweep_done}, {7'd0, ed});
    check({nm, ".busy"},  {7'd0, busy}, {7'd0, eb});
    check({nm, ".state"}, {7'd0, dbg_state}, {7'd0, eb});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    ch_mask = 8'h00; dwell = 8'h00;

    vecs.push_back(mk("rst0", 1, 0, 0, 0, 8'h00, 8'd0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk("rst1", 1, 1, 0, 0, 8'hFF, 8'd0, 3'd0, 0, 0, 0, 0));

    // Full mask, dwell 0, single sweep.
    vecs.push_back(mk("t1_start", 0, 1, 0, 0, 8'hFF, 8'd0, 3'd0, 1, 1, 0, 1));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk($sformatf("t1_idx%0d", i), 0, 0, 0, 0, 8'hFF, 8'd0,
                        3'(i), 1, 1, 0, 1));
    vecs.push_back(mk("t1_end",  0, 0, 0, 0, 8'hFF, 8'd0, 3'd7, 0, 0, 1, 0));
    vecs.push_back(mk("t1_idle", 0, 0, 0, 0, 8'hFF, 8'd0, 3'd7, 0, 0, 0, 0));

    // Sparse mask 2,5,7 with dwell 2; live mask/dwell changed after start.
    vecs.push_back(mk("t2_start", 0, 1, 0, 0, 8'hA4, 8'd2, 3'd2, 1, 1, 0, 1));
    vecs.push_back(mk("t2_h2a", 0, 0, 0, 1, 8'h00, 8'd0, 3'd2, 1, 0, 0, 1));
    vecs.push_back(mk("t2_h2b", 0, 0, 0, 1, 8'h00, 8'd0, 3'd2, 1, 0, 0, 1));
    vecs.push_back(mk("t2_i5",  0, 0, 0, 1, 8'h00, 8'd0, 3'd5, 1, 1, 0, 1));
    vecs.push_back(mk("t2_h5a", 0, 1, 0, 1, 8'h01, 8'd0, 3'd5, 1, 0, 0, 1));
    vecs.push_back(mk("t2_h5b", 0, 0, 0, 1, 8'h00, 8'd0, 3'd5, 1, 0, 0, 1));
    vecs.push_back(mk("t2_i7",  0, 0, 0, 1, 8'h00, 8'd0, 3'd7, 1, 1, 0, 1));
    vecs.push_back(mk("t2_h7a", 0, 0, 0, 1, 8'h00, 8'd0, 3'd7, 1, 0, 0, 1));
    vecs.push_back(mk("t2_h7b", 0, 0, 0, 1, 8'h00, 8'd0, 3'd7, 1, 0, 0, 1));
    vecs.push_back(mk("t2_end", 0, 0, 0, 1, 8'h00, 8'd0, 3'd7, 0, 0, 1, 0));

    // Ignored starts, then reset mid-sweep at idx 3.
    vecs.push_back(mk("t5_zero",  0, 1, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 0, 0));
    vecs.push_back(mk("t5_both",  0, 1, 1, 0, 8'hFF, 8'd0, 3'd7, 0, 0, 0, 0));
    vecs.push_back(mk("t5_start", 0, 1, 0, 0, 8'hFF, 8'd0, 3'd0, 1, 1, 0, 1));
    vecs.push_back(mk("t5_i1",    0, 0, 0, 0, 8'hFF, 8'd0, 3'd1, 1, 1, 0, 1));
    vecs.push_back(mk("t5_i2",    0, 0, 0, 0, 8'hFF, 8'd0, 3'd2, 1, 1, 0, 1));
    vecs.push_back(mk("t5_i3",    0, 0, 0, 0, 8'hFF, 8'd0, 3'd3, 1, 1, 0, 1));
    vecs.push_back(mk("t5_rst",   1, 0, 0, 0, 8'hFF, 8'd0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk("t5_after", 0, 0, 0, 0, 8'hFF, 8'd0, 3'd0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].st, vecs[i].sp, vecs[i].c, vecs[i].m, vecs[i].d);
      check_outs(vecs[i].name, vecs[i].e_idx, vecs[i].e_v, vecs[i].e_s,
                 vecs[i].e_d, vecs[i].e_b);
    end

    // Continuous mode over channels 0 and 7; inputs scrambled after start.
    for (int i = 0; i < 10; i++) exp_q.push_back(((i % 4) < 2) ? 3'd0 : 3'd7);
    cycle(0, 1, 0, 1, 8'h81, 8'd1);
    for (int i = 0; i < 10; i++) begin
      logic [2:0] e;
      if (i > 0) cycle(0, 0, 0, 0, 8'hFF, 8'd5);
      e = exp_q.pop_front();
      check_outs($sformatf("t3_c%0d", i), e, 1'b1, (i % 2) == 0,
                 (i > 0) && ((i % 4) == 0), 1'b1);
    end
    cycle(0, 0, 1, 0, 8'hFF, 8'd5);
    check("t3_stop.valid", {7'd0, idx_valid}, 8'd0);
    check("t3_stop.done",  {7'd0, sweep_done}, 8'd0);
    check("t3_stop.busy",  {7'd0, busy}, 8'd0);

    // Full mask, dwell 3, stop on the first cycle of idx 4, then restart.
    cycle(0, 1, 0, 0, 8'hFF, 8'd3);
    check_outs("t4_c0", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      cycle(0, 0, 0, 0, 8'hFF, 8'd3);
      check_outs($sformatf("t4_c%0d", c), 3'(c / 4), 1'b1, (c % 4) == 0, 1'b0, 1'b1);
    end
    cycle(0, 1, 1, 0, 8'hFF, 8'd3);
    check("t4_stop.valid", {7'd0, idx_valid}, 8'd0);
    check("t4_stop.done",  {7'd0, sweep_done}, 8'd0);
    check("t4_stop.step",  {7'd0, step}, 8'd0);
    check("t4_stop.busy",  {7'd0, busy}, 8'd0);
    cycle(0, 1, 0, 0, 8'hFF, 8'd0);
    check_outs("t4_restart", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(0, 0, 1, 0, 8'hFF, 8'd0);
    check("t4_end.busy", {7'd0, busy}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
